// File: rtl/freq_to_clk.sv
// Piecewise-linear frequency ramp driving a phase-accumulator NCO.
// Each rising edge of the generated clock samples in_data into a hold register.
module freq_to_clk #(
    parameter int unsigned       FREQ_W = 32,
    parameter int unsigned       DATA_W = 16,
    parameter int unsigned       T0     = 20,
    parameter int unsigned       T1     = 80,
    parameter logic [FREQ_W-1:0] F0     = 32'h4000_0000,
    parameter logic [FREQ_W-1:0] F1     = 32'h0400_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freq_sel,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic [DATA_W-1:0] in_data,
    output logic [FREQ_W-1:0] freq_word,
    output logic              clk_out,
    output logic              sample_tick,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned TW = $clog2(T1 + 1);
    localparam logic [TW-1:0] T0_C   = TW'(T0);
    localparam logic [TW-1:0] T1_C   = TW'(T1);
    localparam logic [TW-1:0] T1M1_C = TW'(T1 - 1);

    // Signed slope, truncated toward zero; the final ramp step loads F1 to absorb the residue.
    localparam longint STEP_L = (longint'(F1) - longint'(F0)) / longint'(T1 - T0);
    localparam logic [FREQ_W-1:0] STEP = FREQ_W'(STEP_L);

    logic [TW-1:0]     t;
    logic [FREQ_W-1:0] acc;
    logic [FREQ_W-1:0] acc_next;
    logic [FREQ_W-1:0] active_word;
    logic              rise;

    always_comb begin
        active_word = freq_sel ? freq_in : freq_word;
        acc_next    = acc + active_word;
        rise        = ~acc[FREQ_W-1] & acc_next[FREQ_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (t != T1_C) begin
            t <= t + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_word <= F0;
        end else if (t >= T0_C && t < T1M1_C) begin
            freq_word <= freq_word + STEP;
        end else if (t == T1M1_C) begin
            freq_word <= F1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            sample_tick <= 1'b0;
            out_data    <= '0;
        end else begin
            acc         <= acc_next;
            sample_tick <= rise;
            if (rise) begin
                out_data <= in_data;
            end
        end
    end

    assign clk_out = acc[FREQ_W-1];

endmodule

// File: tb/tb_freq_to_clk.sv
// Scoreboard bench for freq_to_clk: expected ticks (edge, data) are queued by the
// stimulus and consumed by an independent monitor; ramp words are checked directly.
module tb_freq_to_clk;

    logic        clk;
    logic        rst;
    logic        freq_sel;
    logic [31:0] freq_in;
    logic [15:0] in_data;
    logic [31:0] freq_word;
    logic        clk_out;
    logic        sample_tick;
    logic [15:0] out_data;

    typedef struct {
        int          e;
        logic [15:0] d;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    int   se       = 0;
    bit   sb_on    = 0;

    freq_to_clk #(
        .FREQ_W(32),
        .DATA_W(16),
        .T0    (20),
        .T1    (80),
        .F0    (32'h4000_0000),
        .F1    (32'h0400_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freq_sel   (freq_sel),
        .freq_in    (freq_in),
        .in_data    (in_data),
        .freq_word  (freq_word),
        .clk_out    (clk_out),
        .sample_tick(sample_tick),
        .out_data   (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, se, act, exp);
        end
    endtask

    task automatic push(input int e, input logic [15:0] d);
        exp_t x;
        x.e = e;
        x.d = d;
        sbq.push_back(x);
    endtask

    task automatic nxt();
        @(negedge clk);
        se++;
    endtask

    task automatic do_reset();
        sb_on = 0;
        sbq.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_freq_word", 64'(freq_word), 64'h4000_0000);
        check("rst_clk_out", 64'(clk_out), 64'h0);
        check("rst_tick", 64'(sample_tick), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        rst = 1'b0;
        se  = 0;
    endtask

    // Monitor: counts edges since reset release and matches every tick against the queue
    always begin
        exp_t x;
        @(posedge clk);
        if (rst) edge_n = 0;
        else edge_n++;
        #1;
        if (sb_on && sample_tick) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL tick_unexpected edge=%0d actual_data=%0h required=no_tick", edge_n, out_data);
            end else begin
                x = sbq.pop_front();
                if (x.e != edge_n || x.d !== out_data) begin
                    failures++;
                    $display("FAIL tick_match actual edge=%0d data=%0h required edge=%0d data=%0h",
                             edge_n, out_data, x.e, x.d);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        freq_sel = 1'b0;
        freq_in  = '0;
        in_data  = '0;

        // Default ramp with a 16-cycle sawtooth on in_data
        do_reset();
        push(2, 16'd2); push(6, 16'd6); push(10, 16'd10); push(14, 16'd14); push(18, 16'd2);
        push(107, 16'd11); push(171, 16'd11); push(235, 16'd11);
        while (se < 240) begin
            in_data = 16'((se + 1) % 16);
            sb_on   = (se + 1 <= 22) || (se + 1 >= 100);
            nxt();
            case (se)
                1:   check("pwl_e1", 64'(freq_word), 64'h4000_0000);
                20:  check("pwl_e20", 64'(freq_word), 64'h4000_0000);
                21:  check("pwl_e21", 64'(freq_word), 64'h3F00_0000);
                50:  check("pwl_e50", 64'(freq_word), 64'h2200_0000);
                79:  check("pwl_e79", 64'(freq_word), 64'h0500_0000);
                80:  check("pwl_e80", 64'(freq_word), 64'h0400_0000);
                240: check("pwl_e240", 64'(freq_word), 64'h0400_0000);
                default: ;
            endcase
        end
        check("sb_drain_ramp", 64'(sbq.size()), 64'h0);

        // Reset asserted mid-ramp, then the ramp restarts
        do_reset();
        in_data = 16'h1234;
        while (se < 50) nxt();
        check("mid_word_e50", 64'(freq_word), 64'h2200_0000);
        check("mid_out_data", 64'(out_data), 64'h1234);
        rst = 1'b1;
        #1;
        check("mid_rst_word", 64'(freq_word), 64'h4000_0000);
        check("mid_rst_out_data", 64'(out_data), 64'h0);
        check("mid_rst_clk_out", 64'(clk_out), 64'h0);
        check("mid_rst_tick", 64'(sample_tick), 64'h0);
        repeat (3) nxt();
        check("mid_rst_hold_word", 64'(freq_word), 64'h4000_0000);
        rst = 1'b0;
        se  = 0;
        while (se < 21) begin
            nxt();
            if (se == 20) check("rerun_e20", 64'(freq_word), 64'h4000_0000);
            if (se == 21) check("rerun_e21", 64'(freq_word), 64'h3F00_0000);
        end

        // External quarter-rate word, in_data = edge number
        freq_sel = 1'b1;
        freq_in  = 32'h4000_0000;
        do_reset();
        sb_on = 1;
        push(2, 16'd2); push(6, 16'd6); push(10, 16'd10); push(14, 16'd14);
        while (se < 16) begin
            in_data = 16'(se + 1);
            nxt();
            case (se)
                1: check("q_clk_e1", 64'(clk_out), 64'h0);
                2: check("q_clk_e2", 64'(clk_out), 64'h1);
                3: check("q_clk_e3", 64'(clk_out), 64'h1);
                4: check("q_clk_e4", 64'(clk_out), 64'h0);
                default: ;
            endcase
        end
        check("sb_drain_quarter", 64'(sbq.size()), 64'h0);

        // Nyquist word, then a zero word freezes the accumulator
        freq_in = 32'h8000_0000;
        do_reset();
        sb_on = 1;
        push(1, 16'd101); push(3, 16'd103); push(5, 16'd105); push(7, 16'd107);
        while (se < 8) begin
            in_data = 16'(100 + se + 1);
            nxt();
            check("nyq_clk_out", 64'(clk_out), 64'(se % 2));
        end
        freq_in = 32'h0;
        in_data = 16'hBEEF;
        repeat (100) nxt();
        check("zero_hold_data", 64'(out_data), 64'd107);
        check("zero_clk_out", 64'(clk_out), 64'h0);
        check("sb_drain_nyq", 64'(sbq.size()), 64'h0);

        // Word switching keeps phase; freq_sel takes effect on the same edge
        freq_in = 32'h1000_0000;
        do_reset();
        sb_on = 1;
        push(6, 16'd206);
        while (se < 8) begin
            freq_sel = (se + 1 != 4);
            freq_in  = (se + 1 <= 3) ? 32'h1000_0000 : 32'h0800_0000;
            in_data  = 16'(200 + se + 1);
            nxt();
        end
        check("sb_drain_switch", 64'(sbq.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_to_clk.md
FREQ_TO_CLK -- requirements
Module: freq_to_clk

Interface
REQ-001 SHALL take parameters: FREQ_W 32, phase/frequency word width; DATA_W 16, sampled data width (signed).
REQ-002 SHALL take parameters: T0 20, ramp start cycle; T1 80, ramp end cycle (T1 > T0 >= 0).
REQ-003 SHALL take parameters: F0 32'h4000_0000, start frequency word; F1 32'h0400_0000, end frequency word.
REQ-004 SHALL have one clock and an asynchronous active-high reset; all flops SHALL use clk rising edge and rst.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 freq_sel  input  1  1 = use freq_in; 0 = use internal PWL word.
REQ-008 freq_in  input  FREQ_W  external frequency word (unsigned, fraction of fclk times 2^FREQ_W).
REQ-009 in_data  input  DATA_W  signed signal to be sampled.
REQ-010 freq_word  output  FREQ_W  current PWL frequency word (registered).
REQ-011 clk_out  output  1  generated clock, MSB of phase accumulator.
REQ-012 sample_tick  output  1  one-cycle pulse on each generated-clock rising edge.
REQ-013 out_data  output  DATA_W  sample-and-hold output.

Function
REQ-014 PWL: cycle counter t SHALL increment once per clk edge after reset and saturate at T1.
REQ-015 PWL: STEP SHALL be the elaboration-time constant (F1-F0)/(T1-T0), signed, truncated toward zero.
REQ-016 PWL: on each edge, if T0 <= t < T1-1, freq_word SHALL become freq_word+STEP (mod 2^FREQ_W); if t == T1-1 it SHALL load F1 exactly; otherwise it SHALL hold.
REQ-017 Result after n edges from reset release: n <= T0 gives F0; T0 < n < T1 gives F0+STEP*(n-T0); n >= T1 gives F1 permanently.
REQ-018 Active word SHALL be freq_in when freq_sel=1, else the registered freq_word; freq_sel SHALL be sampled every cycle with no pipeline delay.
REQ-019 NCO: acc (FREQ_W bits) SHALL update acc <= acc + active word, wrapping modulo 2^FREQ_W with no saturation.
REQ-020 clk_out SHALL equal acc[FREQ_W-1] (registered, glitch-free).
REQ-021 sample_tick SHALL be set on an edge where acc[MSB] goes 0 -> 1 (old MSB 0, new MSB 1), and cleared on all other edges.
REQ-022 Sampler: on the same edge that sets sample_tick, out_data SHALL capture in_data; otherwise it SHALL hold.
REQ-023 Active word 0 SHALL freeze acc, so there are no ticks and out_data holds.
REQ-024 Active word 2^(FREQ_W-1) SHALL give a tick every 2 cycles (Nyquist limit); larger words alias, and acc MSB rises follow modulo arithmetic only.
REQ-025 Changing the active word mid-period SHALL NOT reset acc; phase SHALL stay continuous.

Reset
REQ-026 While rst=1, regardless of clk: t=0, freq_word=F0, acc=0, clk_out=0, sample_tick=0, out_data=0.
REQ-027 Reset asserted mid-ramp or mid-period SHALL restore the REQ-026 values immediately; the ramp SHALL restart from t=0 after release.

Verification
REQ-028 Default params, freq_sel=0: freq_word is 0x4000_0000 through edge 20, 0x3F00_0000 at edge 21, 0x0500_0000 at edge 79, 0x0400_0000 at edge 80 and after (STEP = -0x0100_0000).
REQ-029 freq_sel=1, freq_in=0x4000_0000, in_data = edge count: acc is 0x4..,0x8..,0xC..,0x0..; sample_tick is high after edges 2, 6, 10, ...; out_data is 2, 6, 10.
REQ-030 freq_in=0x8000_0000: clk_out toggles every edge; sample_tick is high on every second edge; freq_in=0: no tick for 100 cycles and out_data holds its last value.
REQ-031 Default PWL ramp with in_data a fixed 16-cycle sawtooth: tick spacing is 4 cycles before edge 20 and 64 cycles after edge 80; out_data shows the aliased (sub-Nyquist) waveform.
REQ-032 Assert rst at edge 50 mid-ramp for 3 cycles: all outputs are immediately 0 / F0; after release the REQ-028 sequence repeats from edge 0.
REQ-033 Switch freq_sel 0->1 with acc=0x3000_0000 and freq_in=0x1000_0000: next acc is 0x4000_0000 with no phase reset.
